// File: rtl/bally_video_pkg.sv
// Shared constants and types for the Astrocade video timing recovery.
package bally_video_pkg;
    localparam int DIV_DEFAULT       = 16;
    localparam int HBL_START_DEFAULT = 214;
    localparam int HBL_END_DEFAULT   = 34;
    localparam int VBL_START_DEFAULT = 255;
    localparam int VBL_END_DEFAULT   = 25;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;
endpackage

// File: rtl/bally_ce_div.sv
// Clock divider: tick is high while the count sits at DIV-1; ce is tick registered.
// ce is high exactly one cycle in every DIV; no backpressure.
module bally_ce_div
    import bally_video_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk_sys,
    input  logic reset_l,
    output logic tick,
    output logic ce
);
    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk_sys) begin
        if (!reset_l) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else begin
            ce  <= tick;
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/bally_video_timing.sv
// Regenerates H/V counters, blanking, line/frame measurements and frame lock from raw syncs.
// All outputs registered and updated on the pixel tick; the raw syncs cannot be stalled.
module bally_video_timing
    import bally_video_pkg::*;
#(
    parameter int DIV         = DIV_DEFAULT,
    parameter int CNT_W       = 16,
    parameter int HBL_START   = HBL_START_DEFAULT,
    parameter int HBL_END     = HBL_END_DEFAULT,
    parameter int VBL_START   = VBL_START_DEFAULT,
    parameter int VBL_END     = VBL_END_DEFAULT,
    parameter int LOCK_FRAMES = 2,
    parameter int FORCE_BLANK = 1
) (
    input  logic             clk_sys,
    input  logic             reset_l,
    input  logic             hs_in,
    input  logic             vs_in,
    output logic             ce_pix,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic [CNT_W-1:0] pix_per_line,
    output logic [CNT_W-1:0] lines_per_frame,
    output logic             locked
);
    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0]    MATCH_TOP = MW'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] CMAX      = '1;
    localparam logic [CNT_W-1:0] HBS       = CNT_W'(HBL_START);
    localparam logic [CNT_W-1:0] HBE       = CNT_W'(HBL_END);
    localparam logic [CNT_W-1:0] VBS       = CNT_W'(VBL_START);
    localparam logic [CNT_W-1:0] VBE       = CNT_W'(VBL_END);

    logic             tick;
    logic             hs_rise, vs_rise, match, sync_lost, force_blk;
    logic [CNT_W-1:0] hcnt_inc, vcnt_inc, hcnt_nxt, vcnt_nxt;
    logic [MW-1:0]    match_cnt, match_nxt;
    lock_state_t      state, state_nxt;

    bally_ce_div #(.DIV(DIV)) u_ce_div (
        .clk_sys (clk_sys),
        .reset_l (reset_l),
        .tick    (tick),
        .ce      (ce_pix)
    );

    always_comb begin
        hs_rise  = hs_in & ~hsync;
        vs_rise  = hs_rise & vs_in & ~vsync;
        hcnt_inc = (hcnt == CMAX) ? hcnt : hcnt + CNT_W'(1);
        vcnt_inc = (vcnt == CMAX) ? vcnt : vcnt + CNT_W'(1);
        hcnt_nxt = hs_rise ? '0 : hcnt_inc;
        vcnt_nxt = vs_rise ? '0 : (hs_rise ? vcnt_inc : vcnt);
        // vcnt_inc is the frame length about to be latched into lines_per_frame
        match     = (vcnt_inc == lines_per_frame) && (vcnt_inc != '0);
        sync_lost = (hcnt_nxt == CMAX) || (vcnt_nxt == CMAX);

        state_nxt = state;
        match_nxt = match_cnt;
        if (vs_rise) begin
            if (match) begin
                if (match_cnt != MATCH_TOP) match_nxt = match_cnt + MW'(1);
                if (match_nxt == MATCH_TOP) state_nxt = LOCKED;
            end else begin
                match_nxt = '0;
                state_nxt = UNLOCKED;
            end
        end
        if (sync_lost) begin
            match_nxt = '0;
            state_nxt = UNLOCKED;
        end
        force_blk = (FORCE_BLANK != 0) && (state_nxt == UNLOCKED);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_l) begin
            hsync           <= 1'b0;
            vsync           <= 1'b0;
            hcnt            <= '0;
            vcnt            <= '0;
            pix_per_line    <= '0;
            lines_per_frame <= '0;
            hblank          <= 1'b1;
            vblank          <= 1'b1;
            state           <= UNLOCKED;
            match_cnt       <= '0;
            locked          <= 1'b0;
        end else if (tick) begin
            hsync <= hs_in;
            hcnt  <= hcnt_nxt;
            vcnt  <= vcnt_nxt;
            if (hs_rise) begin
                pix_per_line <= hcnt_inc;
                vsync        <= vs_in;
            end
            if (vs_rise) lines_per_frame <= vcnt_inc;
            state     <= state_nxt;
            match_cnt <= match_nxt;
            locked    <= (state_nxt == LOCKED);
            // Blanks decode next-state counters so they line up with hcnt/vcnt
            hblank <= force_blk || (hcnt_nxt >= HBS) || (hcnt_nxt < HBE);
            vblank <= force_blk || (vcnt_nxt >= VBS) || (vcnt_nxt < VBE);
        end
    end
endmodule

// File: tb/tb_bally_video_timing.sv
// Bench for bally_video_timing: per-cycle check against a frame-level model plus directed literals.
// Geometry is scaled down (DIV 4, 10-bit counters, 20-tick lines, 12/13-line frames) to keep the run short.
module tb_bally_video_timing;
    localparam int DIV   = 4;
    localparam int CW    = 10;
    localparam int HBS   = 16;
    localparam int HBE   = 3;
    localparam int VBS   = 10;
    localparam int VBE   = 2;
    localparam int LOCKF = 2;
    localparam int FB    = 1;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int LINE  = 20;

    logic          clk_sys = 1'b0;
    logic          reset_l = 1'b0;
    logic          hs_in   = 1'b0;
    logic          vs_in   = 1'b0;
    logic          ce_pix, hsync, vsync, hblank, vblank, locked;
    logic [CW-1:0] hcnt, vcnt, pix_per_line, lines_per_frame;

    int tests = 0;
    int fails = 0;

    bally_video_timing #(
        .DIV(DIV), .CNT_W(CW), .HBL_START(HBS), .HBL_END(HBE),
        .VBL_START(VBS), .VBL_END(VBE), .LOCK_FRAMES(LOCKF), .FORCE_BLANK(FB)
    ) dut (
        .clk_sys(clk_sys), .reset_l(reset_l), .hs_in(hs_in), .vs_in(vs_in),
        .ce_pix(ce_pix), .hsync(hsync), .vsync(vsync), .hblank(hblank),
        .vblank(vblank), .hcnt(hcnt), .vcnt(vcnt), .pix_per_line(pix_per_line),
        .lines_per_frame(lines_per_frame), .locked(locked)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: lock is a run of equal frame lengths (the held value counts as the first).
    int m_cyc, m_h, m_v, m_ppl, m_lpf, m_run;
    bit m_hs, m_vs, m_ce, m_valid = 1'b0;

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic bit m_locked();
        return (m_run > LOCKF) && (m_lpf != 0);
    endfunction

    task automatic model_tick(input bit hs, input bit vs);
        int meas;
        if (hs && !m_hs) begin
            m_ppl = sat(m_h + 1);
            m_h   = 0;
            if (vs && !m_vs) begin
                meas  = sat(m_v + 1);
                m_run = (meas == m_lpf) ? m_run + 1 : 1;
                m_lpf = meas;
                m_v   = 0;
            end else begin
                m_v = sat(m_v + 1);
            end
            m_vs = vs;
        end else begin
            m_h = sat(m_h + 1);
        end
        m_hs = hs;
        if (m_h == CMAX || m_v == CMAX) m_run = 1;
    endtask

    always @(posedge clk_sys) begin
        if (!reset_l) begin
            m_cyc = 0; m_h = 0; m_v = 0; m_ppl = 0; m_lpf = 0; m_run = 1;
            m_hs = 0; m_vs = 0; m_ce = 0; m_valid = 1'b1;
        end else begin
            m_cyc++;
            m_ce = (m_cyc % DIV) == 0;
            if (m_ce) model_tick(hs_in, vs_in);
        end
        #1;
        if (m_valid) begin
            check("m_ce_pix", ce_pix, m_ce);
            check("m_hcnt", hcnt, m_h);
            check("m_vcnt", vcnt, m_v);
            check("m_hsync", hsync, m_hs);
            check("m_vsync", vsync, m_vs);
            check("m_ppl", pix_per_line, m_ppl);
            check("m_lpf", lines_per_frame, m_lpf);
            check("m_locked", locked, m_locked());
            check("m_hblank", hblank, (FB != 0 && !m_locked()) || m_h >= HBS || m_h < HBE);
            check("m_vblank", vblank, (FB != 0 && !m_locked()) || m_v >= VBS || m_v < VBE);
        end
    end

    task automatic wait_ticks(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin
                @(negedge clk_sys);
                guard++;
            end while (!ce_pix && guard <= 2 * DIV);
            if (!ce_pix) begin
                tests++;
                fails++;
                $display("FAIL tick_timeout: no ce_pix within %0d cycles at %0t", 2 * DIV, $time);
            end
        end
    endtask

    task automatic run_line(input bit vs);
        hs_in = 1'b1;
        vs_in = vs;
        wait_ticks(4);
        hs_in = 1'b0;
        wait_ticks(LINE - 4);
    endtask

    task automatic run_frame(input int len);
        for (int l = 0; l < len; l++) run_line(l < 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_sys);
        check("rst_ce", ce_pix, 0);
        check("rst_hcnt", hcnt, 0);
        check("rst_hblank", hblank, 1);
        check("rst_vblank", vblank, 1);
        check("rst_locked", locked, 0);
        check("rst_hsync", hsync, 0);

        reset_l = 1'b1;
        for (int e = 1; e <= 3 * DIV; e++) begin
            @(posedge clk_sys); #1;
            check("div_pulse", ce_pix, (e % DIV) == 0);
        end
        @(negedge clk_sys);

        for (int l = 0; l < 11; l++) run_line(1'b0);
        check("pre_vcnt", vcnt, 11);
        check("pre_lpf", lines_per_frame, 0);

        for (int f = 1; f <= 4; f++) begin
            run_frame(12);
            check("meas_lpf", lines_per_frame, 12);
            check("meas_ppl", pix_per_line, 20);
            check("lock_after_frame", locked, f >= 3);
        end

        // 13-line frame whose first line walks the hblank window edges
        hs_in = 1'b1; vs_in = 1'b1;
        wait_ticks(1);
        check("win_h0", hcnt, 0);
        check("win_hb0", hblank, 1);
        check("win_vb0", vblank, 1);
        check("win_locked", locked, 1);
        wait_ticks(2);
        check("win_hb2", hblank, 1);
        wait_ticks(1);
        hs_in = 1'b0;
        check("win_h3", hcnt, 3);
        check("win_hb3", hblank, 0);
        wait_ticks(12);
        check("win_hb15", hblank, 0);
        wait_ticks(1);
        check("win_h16", hcnt, 16);
        check("win_hb16", hblank, 1);
        wait_ticks(3);
        for (int l = 1; l < 13; l++) begin
            run_line(l < 3);
            if (l == 1)  check("win_vb1", vblank, 1);
            if (l == 2)  check("win_vb2", vblank, 0);
            if (l == 9)  check("win_vb9", vblank, 0);
            if (l == 10) check("win_vb10", vblank, 1);
        end
        check("chg_pre_locked", locked, 1);

        for (int f = 6; f <= 8; f++) begin
            run_frame(13);
            check("chg_lpf", lines_per_frame, 13);
            check("chg_locked", locked, f == 8);
        end

        for (int l = 0; l < 5; l++) run_line(l < 3);
        check("loss_pre_locked", locked, 1);
        wait_ticks(CMAX - 1 - (LINE - 1));
        check("loss_h1022", hcnt, CMAX - 1);
        check("loss_locked_before", locked, 1);
        check("loss_vb_before", vblank, 0);
        wait_ticks(1);
        check("loss_hsat", hcnt, CMAX);
        check("loss_locked", locked, 0);
        check("loss_hb", hblank, 1);
        check("loss_vb", vblank, 1);
        wait_ticks(20);
        check("loss_hold", hcnt, CMAX);

        for (int l = 0; l < 3; l++) run_line(1'b0);
        hs_in = 1'b1;
        wait_ticks(4);
        hs_in = 1'b0;
        wait_ticks(6);
        check("mid_hcnt", hcnt, 9);
        check("mid_vcnt", vcnt, 8);
        reset_l = 1'b0;
        @(posedge clk_sys); #1;
        check("mid_rst_hcnt", hcnt, 0);
        check("mid_rst_vcnt", vcnt, 0);
        check("mid_rst_ppl", pix_per_line, 0);
        check("mid_rst_lpf", lines_per_frame, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_hblank", hblank, 1);
        check("mid_rst_ce", ce_pix, 0);
        @(negedge clk_sys);
        reset_l = 1'b1;
        for (int e = 1; e <= 2 * DIV; e++) begin
            @(posedge clk_sys); #1;
            check("mid_div_pulse", ce_pix, (e % DIV) == 0);
        end
        @(negedge clk_sys);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
